// File: rtl/daug_dram_sequencer.sv
// daug_dram_sequencer
// RAS/CAS/mux sequencer and CAS-before-RAS refresh arbiter for the 256 KB
// daughterboard DRAM array (8x 41464, banks J/K/L/M). One CPU-side requester.
// Every output is registered from the current state, so strobes trail the
// state register by one clock.
// Optional feature: define DAUG_WPRO_EN to add the write-protect flag
// (WPRO_SET/WPRO_CLR inputs, WPRO/WP_HIT outputs).
module daug_dram_sequencer #(
    parameter int unsigned T_RCD        = 2,
    parameter int unsigned T_CAS        = 3,
    parameter int unsigned T_RP         = 3,
    parameter int unsigned T_REF_RAS    = 4,
    parameter int unsigned REF_INTERVAL = 447
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       REQ,
    input  logic       RW,
    input  logic       _UDS,
    input  logic       _LDS,
    input  logic       A17,
`ifdef DAUG_WPRO_EN
    input  logic       WPRO_SET,
    input  logic       WPRO_CLR,
    output logic       WPRO,
    output logic       WP_HIT,
`endif
    output logic       ACK,
    output logic       _RAS,
    output logic [3:0] _CAS,
    output logic       _W,
    output logic       MUX_COL,
    output logic       BUSY,
    output logic       REF_OVF
);

    localparam int unsigned TW = $clog2(REF_INTERVAL);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(REF_INTERVAL - 1);
    localparam logic [2:0] RCD_LAST = 3'(T_RCD - 1);
    localparam logic [2:0] CAS_LAST = 3'(T_CAS - 1);
    localparam logic [2:0] RP_LAST  = 3'(T_RP - 1);
    localparam logic [2:0] REF_LAST = 3'(T_REF_RAS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ROW,
        S_COL,
        S_REF_CAS,
        S_REF_RAS,
        S_PRE
    } state_t;

    state_t          state;
    logic [2:0]      cnt;
    logic [TW-1:0]   timer;
    logic [1:0]      pending;
    logic            ref_tick;
    logic            ref_done;
    logic            lat_rw;
    logic            lat_uds;
    logic            lat_lds;
    logic            lat_a17;
    logic            w_level;
    logic [3:0]      col_cas;

    assign ref_tick = (timer == '0);
    assign ref_done = (state == S_REF_RAS) && (cnt == REF_LAST);

    // Column strobes {M,L,K,J}: upper byte -> L/M, lower byte -> J/K, A17 picks the pair
    assign col_cas = {lat_uds | ~lat_a17,
                      lat_uds |  lat_a17,
                      lat_lds | ~lat_a17,
                      lat_lds |  lat_a17};

`ifdef DAUG_WPRO_EN
    logic lat_wp;

    // A protected write keeps _W high for the whole access
    assign w_level = lat_rw | lat_wp;

    // Sticky write-protect flag; a coincident set beats clear
    always_ff @(posedge CLK) begin
        if (RST)
            WPRO <= 1'b0;
        else if (WPRO_SET)
            WPRO <= 1'b1;
        else if (WPRO_CLR)
            WPRO <= 1'b0;
    end
`else
    assign w_level = lat_rw;
`endif

    // Refresh interval timer and pending-refresh counter with overflow flag
    always_ff @(posedge CLK) begin
        if (RST) begin
            timer   <= TIMER_LOAD;
            pending <= '0;
            REF_OVF <= 1'b0;
        end else begin
            timer <= ref_tick ? TIMER_LOAD : timer - TW'(1);
            if (ref_tick && !ref_done) begin
                if (pending == 2'd3)
                    REF_OVF <= 1'b1;
                else
                    pending <= pending + 2'd1;
            end else if (!ref_tick && ref_done && pending != 2'd0) begin
                pending <= pending - 2'd1;
            end
        end
    end

    // Main sequencer: state walk plus strobes registered from the current state
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= S_IDLE;
            cnt     <= '0;
            lat_rw  <= 1'b1;
            lat_uds <= 1'b1;
            lat_lds <= 1'b1;
            lat_a17 <= 1'b0;
            ACK     <= 1'b0;
            _RAS    <= 1'b1;
            _CAS    <= '1;
            _W      <= 1'b1;
            MUX_COL <= 1'b0;
            BUSY    <= 1'b0;
`ifdef DAUG_WPRO_EN
            lat_wp  <= 1'b0;
            WP_HIT  <= 1'b0;
`endif
        end else begin
            ACK     <= 1'b0;
            _RAS    <= 1'b1;
            _CAS    <= '1;
            _W      <= 1'b1;
            MUX_COL <= 1'b0;
            BUSY    <= (state != S_IDLE);
`ifdef DAUG_WPRO_EN
            WP_HIT  <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    // A timer expiry on this edge counts as pending, so refresh beats REQ
                    if (pending != 2'd0 || ref_tick) begin
                        state <= S_REF_CAS;
                    end else if (REQ) begin
                        lat_rw  <= RW;
                        lat_uds <= _UDS;
                        lat_lds <= _LDS;
                        lat_a17 <= A17;
`ifdef DAUG_WPRO_EN
                        lat_wp  <= WPRO & ~RW;
`endif
                        state   <= S_ROW;
                    end
                end
                S_ROW: begin
                    _RAS <= 1'b0;
                    _W   <= w_level;
                    if (cnt == RCD_LAST) begin
                        cnt   <= '0;
                        state <= S_COL;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                S_COL: begin
                    _RAS    <= 1'b0;
                    MUX_COL <= 1'b1;
                    _W      <= w_level;
                    _CAS    <= col_cas;
                    if (cnt == CAS_LAST) begin
                        ACK   <= 1'b1;
`ifdef DAUG_WPRO_EN
                        WP_HIT <= lat_wp;
`endif
                        cnt   <= '0;
                        state <= S_PRE;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                S_REF_CAS: begin
                    _CAS  <= '0;
                    cnt   <= '0;
                    state <= S_REF_RAS;
                end
                S_REF_RAS: begin
                    _CAS <= '0;
                    _RAS <= 1'b0;
                    if (cnt == REF_LAST) begin
                        cnt   <= '0;
                        state <= S_PRE;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                S_PRE: begin
                    if (cnt == RP_LAST) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
